// File: rtl/uart_tx_module.sv
// uart_tx_module: self-timed UART transmitter with a one-entry holding buffer.
// Frame on the line: start (0), 8 data bits LSB first, even parity, stop (1);
// every bit lasts CLKS_PER_BIT clocks. A byte waiting in the holding buffer is
// launched straight out of the stop bit, so back-to-back frames have no gap.
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      asynchronous active-low reset
//   enable     permits a new frame to start; never aborts one in progress
//   data_in    byte to send, captured when load && ready
//   load       producer valid strobe
//   ready      holding buffer empty (registered)
//   tx         serial line, idles high (registered)
//   busy       a frame is on the line (registered)
//   frame_done one-cycle pulse on the last cycle of the stop bit (registered)
module uart_tx_module #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q, ready_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             bit_end;
  logic             load_take;
  logic             launch;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      ready_q      <= 1'b1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      ready_q      <= ready_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    tx_d         = 1'b1;
    busy_d       = 1'b0;
    ready_d      = 1'b1;
    frame_done_d = 1'b0;

    bit_end   = (cnt_q == CNT_LAST);
    // ready_q mirrors an empty buffer, so a take and a launch never coincide
    load_take = load && ready_q;
    launch    = hold_full_q && enable &&
                ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Move the waiting byte into the shifter, from IDLE or out of the stop bit
    if (launch) begin
      state_d     = START;
      cnt_d       = '0;
      shift_d     = hold_q;
      parity_d    = ^hold_q;
      hold_full_d = 1'b0;
    end

    if (load_take) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    // Line level follows the state the register will hold next cycle
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d       = (state_d != IDLE);
    ready_d      = !hold_full_d;
    // Registered one cycle early so the pulse lands on the last stop cycle
    frame_done_d = (state_q == STOP) && (cnt_q == CNT_PRE);
  end

  assign ready      = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// tb_uart_tx_module: scenario tasks for uart_tx_module checked against a
// frame-level model of the serial line (start, data LSB first, even parity,
// stop), each bit lasting CPB clocks.
module tb_uart_tx_module;

  localparam int unsigned CPB   = 8;
  localparam int unsigned FRAME = 11 * CPB;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       enable  = 1'b0;
  logic       load    = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_module #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .load       (load),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Expected line level c clocks after the start bit began
  function automatic logic exp_line(input logic [7:0] b, input int unsigned c);
    int unsigned k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[3'(k - 1)];
    if (k == 9) return 1'($countones(b) % 2);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({tx, ready, busy, frame_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_held: tx/ready/busy/done=%b%b%b%b expected 1100", tx, ready, busy, frame_done);
    end
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({tx, ready, busy, frame_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_released: tx/ready/busy/done=%b%b%b%b expected 1100", tx, ready, busy, frame_done);
    end
  endtask

  task automatic test_basic();
    logic [10:0] ref05;
    logic        exp_t;
    ref05  = 11'b10000001010;
    enable = 1'b1;
    load = 1'b1; data_in = 8'h05;
    tick();
    load = 1'b0; data_in = 8'($urandom);
    n_checks++;
    if ({tx, ready, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_accept: tx/ready/busy=%b%b%b expected 100", tx, ready, busy);
    end
    tick();
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready_after_launch: ready=%b expected 1", ready);
    end
    for (int c = 0; c < int'(FRAME); c++) begin
      exp_t = ref05[c / int'(CPB)];
      n_checks++;
      if ({tx, busy, frame_done} !== {exp_t, 1'b1, 1'(c == int'(FRAME) - 1)}) begin
        n_fail++;
        $display("FAIL basic_frame cycle %0d: tx/busy/done=%b%b%b expected %b1%b",
                 c, tx, busy, frame_done, exp_t, c == int'(FRAME) - 1);
      end
      tick();
    end
    n_checks++;
    if ({tx, ready, busy, frame_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL basic_idle_after: tx/ready/busy/done=%b%b%b%b expected 1100", tx, ready, busy, frame_done);
    end
  endtask

  task automatic test_parity();
    logic [7:0] fixed   [3] = '{8'h07, 8'hFF, 8'h00};
    logic       par_tab [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] b;
    logic       exp_t;
    int         gap;
    for (int i = 0; i < 8; i++) begin
      b   = (i < 3) ? fixed[i] : 8'($urandom);
      gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) begin
        n_checks++;
        if ({tx, busy} !== 2'b10) begin
          n_fail++;
          $display("FAIL parity_gap byte %0d: tx/busy=%b%b expected 10", i, tx, busy);
        end
        tick();
      end
      load = 1'b1; data_in = b;
      tick();
      load = 1'b0;
      tick();
      for (int c = 0; c < int'(FRAME); c++) begin
        exp_t = exp_line(b, c);
        n_checks++;
        if ({tx, busy, frame_done} !== {exp_t, 1'b1, 1'(c == int'(FRAME) - 1)}) begin
          n_fail++;
          $display("FAIL parity_frame byte %02h cycle %0d: tx/busy/done=%b%b%b expected %b1%b",
                   b, c, tx, busy, frame_done, exp_t, c == int'(FRAME) - 1);
        end
        if (i < 3 && c == int'(9 * CPB + CPB / 2)) begin
          n_checks++;
          if (tx !== par_tab[i]) begin
            n_fail++;
            $display("FAIL parity_bit byte %02h: tx=%b expected %b", b, tx, par_tab[i]);
          end
        end
        tick();
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_busy_after byte %02h: busy=%b expected 0", b, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2] = '{8'h07, 8'hA3};
    logic       exp_t;
    int         f;
    int         cc;
    load = 1'b1; data_in = bytes[0];
    tick();
    load = 1'b0;
    tick();
    for (int c = 0; c < 2 * int'(FRAME); c++) begin
      if (c == 0) begin load = 1'b1; data_in = bytes[1]; end
      if (c == 1) begin
        load = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_second_accept: ready=%b expected 0", ready);
        end
      end
      f     = c / int'(FRAME);
      cc    = c % int'(FRAME);
      exp_t = exp_line(bytes[f], cc);
      n_checks++;
      if ({tx, busy, frame_done} !== {exp_t, 1'b1, 1'(cc == int'(FRAME) - 1)}) begin
        n_fail++;
        $display("FAIL b2b_frame cycle %0d: tx/busy/done=%b%b%b expected %b1%b",
                 c, tx, busy, frame_done, exp_t, cc == int'(FRAME) - 1);
      end
      tick();
    end
    n_checks++;
    if ({tx, busy, ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_idle_after: tx/busy/ready=%b%b%b expected 101", tx, busy, ready);
    end
  endtask

  // load held high with data changing every cycle; from idle the accepting
  // edges are 0, 2 and 2+FRAME (one per freed buffer slot)
  task automatic test_handshake();
    logic [7:0] vals [FRAME + 3];
    logic [7:0] exp_b [3];
    logic       exp_t;
    logic       idle_ok;
    int         f;
    int         cc;
    for (int e = 0; e < int'(FRAME) + 3; e++) vals[e] = 8'($urandom);
    exp_b[0] = vals[0];
    exp_b[1] = vals[2];
    exp_b[2] = vals[2 + FRAME];
    fork
      begin
        load = 1'b1;
        for (int e = 0; e <= int'(FRAME) + 2; e++) begin
          data_in = vals[e];
          tick();
        end
        load = 1'b0;
      end
      begin
        tick();
        n_checks++;
        if ({tx, ready} !== 2'b10) begin
          n_fail++;
          $display("FAIL hs_first_accept: tx/ready=%b%b expected 10", tx, ready);
        end
        tick();
        for (int c = 0; c < 3 * int'(FRAME); c++) begin
          f     = c / int'(FRAME);
          cc    = c % int'(FRAME);
          exp_t = exp_line(exp_b[f], cc);
          n_checks++;
          if ({tx, busy, frame_done} !== {exp_t, 1'b1, 1'(cc == int'(FRAME) - 1)}) begin
            n_fail++;
            $display("FAIL hs_frame %0d byte %02h cycle %0d: tx/busy/done=%b%b%b expected %b1%b",
                     f, exp_b[f], cc, tx, busy, frame_done, exp_t, cc == int'(FRAME) - 1);
          end
          tick();
        end
      end
    join
    idle_ok = 1'b1;
    for (int c = 0; c < 2 * int'(CPB); c++) begin
      if ({tx, busy, ready} !== 3'b101) idle_ok = 1'b0;
      tick();
    end
    n_checks++;
    if (idle_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_no_extra_frame: line not idle after third frame, got %b expected 1", idle_ok);
    end
  endtask

  task automatic test_enable();
    logic exp_t;
    enable = 1'b0;
    load = 1'b1; data_in = 8'h3C;
    tick();
    load = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL en_accept: ready=%b expected 0", ready);
    end
    for (int c = 0; c < 50; c++) begin
      n_checks++;
      if ({tx, busy, ready} !== 3'b100) begin
        n_fail++;
        $display("FAIL en_hold cycle %0d: tx/busy/ready=%b%b%b expected 100", c, tx, busy, ready);
      end
      tick();
    end
    enable = 1'b1;
    tick();
    for (int c = 0; c < int'(FRAME); c++) begin
      exp_t = exp_line(8'h3C, c);
      n_checks++;
      if ({tx, busy, frame_done} !== {exp_t, 1'b1, 1'(c == int'(FRAME) - 1)}) begin
        n_fail++;
        $display("FAIL en_frame cycle %0d: tx/busy/done=%b%b%b expected %b1%b",
                 c, tx, busy, frame_done, exp_t, c == int'(FRAME) - 1);
      end
      tick();
    end
    n_checks++;
    if ({tx, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL en_idle_after: tx/busy=%b%b expected 10", tx, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_t;
    logic idle_ok;
    load = 1'b1; data_in = 8'hA3;
    tick();
    load = 1'b0;
    tick();
    for (int c = 0; c < 40; c++) begin
      // queue a second byte so the buffer is full when reset hits
      if (c == 0) begin load = 1'b1; data_in = 8'h5A; end
      if (c == 1) load = 1'b0;
      exp_t = exp_line(8'hA3, c);
      n_checks++;
      if ({tx, busy} !== {exp_t, 1'b1}) begin
        n_fail++;
        $display("FAIL rst_pre cycle %0d: tx/busy=%b%b expected %b1", c, tx, busy, exp_t);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({tx, ready, busy, frame_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rst_async: tx/ready/busy/done=%b%b%b%b expected 1100", tx, ready, busy, frame_done);
    end
    tick();
    tick();
    reset = 1'b1;
    idle_ok = 1'b1;
    for (int c = 0; c < 3 * int'(CPB); c++) begin
      if ({tx, ready, busy, frame_done} !== 4'b1100) idle_ok = 1'b0;
      tick();
    end
    n_checks++;
    if (idle_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_buffer_discarded: line not idle after release, got %b expected 1", idle_ok);
    end
    load = 1'b1; data_in = 8'h05;
    tick();
    load = 1'b0;
    tick();
    for (int c = 0; c < int'(FRAME); c++) begin
      exp_t = exp_line(8'h05, c);
      n_checks++;
      if ({tx, busy, frame_done} !== {exp_t, 1'b1, 1'(c == int'(FRAME) - 1)}) begin
        n_fail++;
        $display("FAIL rst_post_frame cycle %0d: tx/busy/done=%b%b%b expected %b1%b",
                 c, tx, busy, frame_done, exp_t, c == int'(FRAME) - 1);
      end
      tick();
    end
    n_checks++;
    if ({tx, busy, ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL rst_post_idle: tx/busy/ready=%b%b%b expected 101", tx, busy, ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_handshake();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
- Serial UART transmitter that produces the 11-bit frames consumed by rx_module.
- Frame format, in line order: start (0), 8 data bits LSB first, even parity, stop (1).
- Replaces the shift_reg_piso + clock_divider stimulus pair with a self-timed, handshaked source.
- Has a one-entry holding buffer so back-to-back frames leave no idle gap on the line.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit (>=2); matches the rx_module bit period.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits frame start; does not abort a frame already in progress.
- data_in  input  8  byte to send; sampled when load && ready.
- load  input  1  producer valid strobe.
- ready  output  1  holding buffer empty; may accept a byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (state != IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (reset==0, async): tx=1, ready=1, busy=0, frame_done=0, state=IDLE, holding buffer empty, counters 0. Deassertion is sampled on the next posedge.
- Load handshake: on a posedge with load && ready, data_in goes into the holding register, and ready=0 from the next cycle. load while ready=0 is ignored; data_in is not captured.
- States: IDLE, START, DATA, PARITY, STOP. Every non-IDLE state lasts CLKS_PER_BIT cycles, timed by a bit counter 0..CLKS_PER_BIT-1.
- IDLE: tx=1. If the holding buffer is full and enable=1:
  - The holding byte moves to the shift register.
  - The buffer is freed: ready=1 next cycle.
  - State goes to START, with tx=0 registered on that same edge.
  - Latency: load accepted at edge N, tx falls after edge N+1.
- START: tx=0, then DATA.
- DATA: tx = shift[0] per bit; shift right at each bit boundary. A 3-bit index counts 0..7; after bit 7 go to PARITY.
- PARITY: tx = ^byte (even parity: total ones across data and parity is even).
- STOP: tx=1.
  - frame_done=1 on the final cycle of STOP.
  - At the end of STOP, if the buffer is full and enable=1, go directly to START: no idle cycle, and the next byte is moved as in IDLE.
  - Otherwise go to IDLE.
- Frame length: exactly 11*CLKS_PER_BIT cycles from tx falling to the end of STOP.
- Simultaneous events:
  - A transfer from buffer to shift register and a load in the same cycle: the load is ignored, because ready is still 0 that cycle.
  - The load is accepted the following cycle at the earliest.
- enable low: the frame in progress completes normally. No new frame starts, but the buffer may still be filled; transmission starts on the first edge with enable=1.
- Reset mid-frame: tx returns to 1 immediately (async), the buffer is discarded, and no frame_done is issued.
- tx, ready, busy and frame_done are all registered outputs. tx has no combinational path from any input.

Test Plan:
1. Reset, enable=1, load 0x05 → tx emits 0,1,0,1,0,0,0,0,0,0,1 (= 11'b10000001010 sent LSB first).
   - Each bit holds 8 clk cycles; frame_done pulses once at cycle 88.
   - Looped into rx_module, its data_out reads 00000101.
2. Parity: load 0x07 → parity bit 1; load 0xFF → parity bit 0; load 0x00 → parity bit 0.
3. Back-to-back: load 0x07, then load 0xA3 as soon as ready=1.
   - Second start bit immediately follows the first stop bit, with no idle cycle.
   - busy stays high for 176 cycles.
4. Handshake: hold load=1 with a changing data_in while ready=0 → only the values sampled on ready=1 edges are transmitted; no byte is duplicated or dropped.
5. enable=0, load 0x3C:
   - ready→0, tx stays 1 for 50 cycles.
   - Raise enable → tx falls 1 cycle later and the frame carries 0x3C.
6. Reset asserted at cycle 40 of a 0xA3 frame → tx=1, busy=0 and ready=1 immediately. After release, a new load 0x05 transmits correctly.
